// File: rtl/pipe_stage_reg_pkg.sv
// Shared stage widths and the write-back control bundle.
// Stage-register instances size CTRL_W/DATA_W from here.
package pipe_stage_reg_pkg;

    localparam int PC_W      = 32;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    // PC+4, rd, ALU result, load data
    localparam int WB_DATA_W = PC_W + REG_IDX_W + XLEN + XLEN;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic    reg_we;
        wb_sel_e wb_sel;
    } wb_ctrl_t;

    localparam int WB_CTRL_W = $bits(wb_ctrl_t);

    typedef struct packed {
        logic [PC_W-1:0]      pc4;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      alu;
        logic [XLEN-1:0]      ld;
    } wb_data_t;

    function automatic logic [1:0] occ_count(
        input logic a,
        input logic b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports: clk, clr (sync clear), inc (count enable), count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    always_comb begin
        at_max = (count == {CNT_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register, optional 2-entry skid.
// Ports: clk, rst (sync, high), flush, in_* / out_* handshake
// channels, occupancy (held entries), stall_cycles (saturating).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int CTRL_W = WB_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic              main_v;
    logic              skid_v;
    logic              rdy_q;
    logic [CTRL_W-1:0] main_c;
    logic [CTRL_W-1:0] skid_c;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;

    logic xfer_in;
    logic xfer_out;
    logic to_main;
    logic to_skid;
    logic skid_to_main;
    logic stall;

    always_comb begin
        if (SKID != 0) begin
            in_ready = rdy_q;
        end else begin
            in_ready = !main_v || out_ready;
        end
        xfer_out     = main_v && out_ready;
        xfer_in      = in_valid && in_ready;
        // skid only fills when main is held this cycle
        to_main      = xfer_in && (!main_v || xfer_out);
        to_skid      = xfer_in && main_v && !xfer_out
                       && (SKID != 0);
        skid_to_main = xfer_out && skid_v;
        stall        = main_v && !out_ready;
    end

    // rdy_q always mirrors !skid_v, kept as its own flop
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
            main_c <= '0;
            main_d <= '0;
            skid_c <= '0;
            skid_d <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            if (skid_to_main) begin
                main_c <= skid_c;
                main_d <= skid_d;
                main_v <= 1'b1;
                skid_v <= 1'b0;
                rdy_q  <= 1'b1;
            end else if (to_main) begin
                main_c <= in_ctrl;
                main_d <= in_data;
                main_v <= 1'b1;
            end else if (xfer_out) begin
                main_v <= 1'b0;
            end
            if (to_skid) begin
                skid_c <= in_ctrl;
                skid_d <= in_data;
                skid_v <= 1'b1;
                rdy_q  <= 1'b0;
            end
        end
    end

    // empty slot presents a bubble: no register write
    always_comb begin
        out_valid = main_v;
        out_ctrl  = main_v ? main_c : '0;
        out_data  = main_d;
        occupancy = occ_count(main_v, skid_v);
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall (
        .clk  (clk),
        .clr  (rst),
        .inc  (stall),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised + directed bench for pipe_stage_reg against a queue model.
// Three instances: SKID=1, SKID=1/CNT_W=2, SKID=0.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int DW = WB_DATA_W;
    localparam int CW = WB_CTRL_W;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic [N-1:0]  ov;
    logic [N-1:0]  ir;
    logic [CW-1:0] oc   [N];
    logic [DW-1:0] od   [N];
    logic [1:0]    occ  [N];
    logic [15:0]   sc0;
    logic [1:0]    sc1;
    logic [15:0]   sc2;

    int checks   = 0;
    int failures = 0;

    // model: per instance FIFO of {ctrl,data}
    logic [CW+DW-1:0] m_q    [N][2];
    int               m_cnt  [N];
    int               m_stall[N];
    logic [DW-1:0]    m_last [N];

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_ctrl(oc[0]), .out_data(od[0]),
        .occupancy(occ[0]), .stall_cycles(sc0)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_ctrl(oc[1]), .out_data(od[1]),
        .occupancy(occ[1]), .stall_cycles(sc1)
    );

    pipe_stage_reg #(.SKID(0), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready),
        .out_ctrl(oc[2]), .out_data(od[2]),
        .occupancy(occ[2]), .stall_cycles(sc2)
    );

    task automatic chk(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit m_skid(input int i);
        return i != 2;
    endfunction

    function automatic int m_max(input int i);
        return (i == 1) ? 3 : 65535;
    endfunction

    function automatic bit m_rdy(input int i);
        if (m_skid(i)) return m_cnt[i] < 2;
        return (m_cnt[i] == 0) || out_ready;
    endfunction

    function automatic logic [127:0] act_sc(input int i);
        case (i)
            0:       return 128'(sc0);
            1:       return 128'(sc1);
            default: return 128'(sc2);
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]   = 0;
            m_stall[i] = 0;
            m_last[i]  = '0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            logic          ev;
            logic [CW-1:0] ec;
            logic [DW-1:0] ed;
            ev = m_cnt[i] > 0;
            ec = ev ? m_q[i][0][CW+DW-1:DW] : '0;
            ed = ev ? m_q[i][0][DW-1:0] : m_last[i];
            chk($sformatf("u%0d.out_valid", i), 128'(ov[i]), 128'(ev));
            chk($sformatf("u%0d.out_ctrl", i), 128'(oc[i]), 128'(ec));
            chk($sformatf("u%0d.out_data", i), 128'(od[i]), 128'(ed));
            chk($sformatf("u%0d.occupancy", i),
                128'(occ[i]), 128'(m_cnt[i]));
            chk($sformatf("u%0d.in_ready", i),
                128'(ir[i]), 128'(m_rdy(i)));
            chk($sformatf("u%0d.stall", i),
                act_sc(i), 128'(m_stall[i]));
        end
    endtask

    // advance the model by one rising edge using current inputs
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit rdy;
            bit pop;
            bit push;
            if (rst) begin
                m_cnt[i]   = 0;
                m_stall[i] = 0;
                m_last[i]  = '0;
                continue;
            end
            if (m_cnt[i] > 0 && !out_ready && m_stall[i] < m_max(i))
                m_stall[i]++;
            if (flush) begin
                m_cnt[i] = 0;
                continue;
            end
            rdy  = m_rdy(i);
            pop  = m_cnt[i] > 0 && out_ready;
            push = in_valid && rdy;
            if (pop) begin
                m_q[i][0] = m_q[i][1];
                m_cnt[i]--;
            end
            if (push) begin
                m_q[i][m_cnt[i]] = {in_ctrl, in_data};
                m_cnt[i]++;
            end
            if (m_cnt[i] > 0) m_last[i] = m_q[i][0][DW-1:0];
        end
    endtask

    task automatic step(
        input bit            r,
        input bit            f,
        input bit            iv,
        input bit            ordy,
        input logic [CW-1:0] c,
        input logic [DW-1:0] d
    );
        rst       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        in_ctrl   = c;
        in_data   = d;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [4:0] lo;
        lo = 5'($urandom_range(31, 0));
        return {$urandom(), $urandom(), $urandom(), lo};
    endfunction

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();

        // reset then idle
        step(1, 0, 0, 0, '0, '0);
        step(0, 0, 0, 0, '0, '0);
        step(0, 0, 0, 1, '0, '0);

        // full-throughput stream 1..4
        for (int k = 1; k <= 4; k++)
            step(0, 0, 1, 1, CW'(k), DW'(k));
        step(0, 0, 0, 1, '0, '0);
        step(0, 0, 0, 1, '0, '0);

        // A then B under back-pressure, then drain one
        step(0, 0, 1, 0, 3'b101, DW'(16'hAAAA));
        step(0, 0, 1, 0, 3'b110, DW'(16'hBBBB));
        step(0, 0, 1, 0, 3'b111, DW'(16'hDDDD));
        step(0, 0, 0, 0, '0, '0);
        step(0, 0, 0, 1, '0, '0);
        step(0, 0, 0, 0, '0, '0);

        // refill to two, flush while C is offered
        step(0, 0, 1, 0, 3'b011, DW'(16'hEEEE));
        step(0, 1, 1, 0, 3'b111, DW'(16'hCCCC));
        step(0, 0, 0, 0, '0, '0);
        step(0, 0, 0, 1, '0, '0);

        // long stall saturates the 2-bit counter
        step(0, 0, 1, 0, 3'b001, DW'(16'h1234));
        repeat (5) step(0, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, '0, '0);
        step(0, 0, 0, 0, '0, '0);
        step(1, 0, 1, 1, 3'b111, DW'(16'h5555));
        step(0, 0, 0, 0, '0, '0);

        // SKID=0 replace-in-one-cycle
        step(0, 0, 1, 0, 3'b100, DW'(16'h0F0F));
        step(0, 0, 1, 0, 3'b010, DW'(16'hF0F0));
        step(0, 0, 1, 1, 3'b001, DW'(16'h7777));
        step(0, 0, 0, 1, '0, '0);

        // random traffic with phased back-pressure
        for (int n = 0; n < 600; n++) begin
            bit r;
            bit f;
            bit iv;
            bit o;
            int pr;
            pr = (n / 100) % 3;
            r  = ($urandom_range(199, 0) == 0);
            f  = ($urandom_range(99, 0) < 3);
            iv = ($urandom_range(3, 0) != 0);
            case (pr)
                0:       o = ($urandom_range(3, 0) != 0);
                1:       o = ($urandom_range(3, 0) == 0);
                default: o = $urandom_range(1, 0) != 0;
            endcase
            step(r, f, iv, o, CW'($urandom_range(7, 0)), rnd_data());
        end
        step(0, 0, 0, 1, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
